// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state/message types and response byte constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_CHECK,
        ST_SEND,
        ST_DONE,
        ST_LOCKOUT
    } state_e;

    typedef enum logic [1:0] {
        MSG_OK,
        MSG_NO,
        MSG_LK
    } msg_e;

    // Byte 0 (first transmitted) sits in [7:0].
    localparam logic [31:0] MSG_OK_BYTES = {8'h0A, 8'h0D, 8'h4B, 8'h4F}; // "OK\r\n"
    localparam logic [31:0] MSG_NO_BYTES = {8'h0A, 8'h0D, 8'h4F, 8'h4E}; // "NO\r\n"
    localparam logic [31:0] MSG_LK_BYTES = {8'h0A, 8'h0D, 8'h4B, 8'h4C}; // "LK\r\n"

endpackage

// File: rtl/uart_pass_ctrl_if.sv
// rtl/uart_pass_ctrl_if.sv - UART byte stream and status bundle for the password controller
// Signals:
//   rxData/rxValid : received byte and its one-cycle strobe (master -> slave)
//   txData/txValid/txReady : response byte handshake (slave offers, master accepts)
//   unlocked/locked/led    : status outputs of the controller
interface uart_pass_ctrl_if;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       unlocked;
    logic       locked;
    logic [5:0] led;

    modport master (
        output rxData, rxValid, txReady,
        input  txData, txValid, unlocked, locked, led
    );

    modport slave (
        input  rxData, rxValid, txReady,
        output txData, txValid, unlocked, locked, led
    );
endinterface

// File: rtl/uart_msg_rom.sv
// rtl/uart_msg_rom.sv - combinational lookup of one response byte
// Ports:
//   sel_i  : which response message
//   ptr_i  : byte position within the 4-byte message
//   data_o : selected byte
module uart_msg_rom
    import uart_pkg::*;
(
    input  msg_e       sel_i,
    input  logic [1:0] ptr_i,
    output logic [7:0] data_o
);

    logic [31:0] word;

    always_comb begin
        case (sel_i)
            MSG_NO:  word = MSG_NO_BYTES;
            MSG_LK:  word = MSG_LK_BYTES;
            default: word = MSG_OK_BYTES;
        endcase
        data_o = word[{ptr_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/uart_pass_ctrl.sv
// rtl/uart_pass_ctrl.sv - password check over a UART byte stream with retry lockout
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of uart_pass_ctrl_if (rx bytes in, response bytes and status out)
module uart_pass_ctrl
    import uart_pkg::*;
#(
    parameter int                    PASS_LEN  = 4,
    parameter logic [8*PASS_LEN-1:0] PASSWORD  = {"B", "2", "a", "1"},
    parameter int                    MAX_TRIES = 3
) (
    input  logic            clk,
    input  logic            rst,
    uart_pass_ctrl_if.slave bus
);

    localparam logic [31:0] PW_WORD  = 32'(PASSWORD);
    localparam logic [1:0]  LAST_IDX = 2'(PASS_LEN - 1);
    localparam logic [1:0]  TRIES_LK = 2'(MAX_TRIES - 1);

    state_e     state_q;
    logic [1:0] idx_q;
    logic [1:0] ptr_q;
    logic [1:0] tries_q;
    logic       mismatch_q;
    msg_e       msg_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       unlocked_q;
    logic       locked_q;

    logic [7:0] pw_byte;
    msg_e       check_sel_d;
    msg_e       rom_sel_d;
    logic [1:0] rom_ptr_d;
    logic [7:0] rom_byte;

    assign pw_byte = PW_WORD[{idx_q, 3'b000} +: 8];

    // In CHECK the message is not registered yet, so the ROM is steered by the
    // freshly decided message to preload byte 0; in SEND it looks one byte ahead.
    always_comb begin
        if (!mismatch_q) begin
            check_sel_d = MSG_OK;
        end else if (tries_q >= TRIES_LK) begin
            check_sel_d = MSG_LK;
        end else begin
            check_sel_d = MSG_NO;
        end

        if (state_q == ST_CHECK) begin
            rom_sel_d = check_sel_d;
            rom_ptr_d = 2'd0;
        end else begin
            rom_sel_d = msg_q;
            rom_ptr_d = ptr_q + 2'd1;
        end
    end

    uart_msg_rom u_rom (
        .sel_i  (rom_sel_d),
        .ptr_i  (rom_ptr_d),
        .data_o (rom_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            idx_q      <= 2'd0;
            ptr_q      <= 2'd0;
            tries_q    <= 2'd0;
            mismatch_q <= 1'b0;
            msg_q      <= MSG_OK;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (bus.rxValid) begin
                        if (bus.rxData != pw_byte) begin
                            mismatch_q <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= 2'd0;
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    mismatch_q <= 1'b0;
                    msg_q      <= check_sel_d;
                    tries_q    <= (check_sel_d == MSG_OK) ? 2'd0 : tries_q + 2'd1;
                    ptr_q      <= 2'd0;
                    tx_data_q  <= rom_byte;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid_q && bus.txReady) begin
                        if (ptr_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                            ptr_q      <= 2'd0;
                            case (msg_q)
                                MSG_OK: begin
                                    state_q    <= ST_DONE;
                                    unlocked_q <= 1'b1;
                                end
                                MSG_LK: begin
                                    state_q  <= ST_LOCKOUT;
                                    locked_q <= 1'b1;
                                end
                                default: state_q <= ST_COLLECT;
                            endcase
                        end else begin
                            ptr_q     <= ptr_q + 2'd1;
                            tx_data_q <= rom_byte;
                        end
                    end
                end
                default: begin
                    // DONE and LOCKOUT hold until reset.
                end
            endcase
        end
    end

    assign bus.txData   = tx_data_q;
    assign bus.txValid  = tx_valid_q;
    assign bus.unlocked = unlocked_q;
    assign bus.locked   = locked_q;
    assign bus.led      = ~{unlocked_q, locked_q, tries_q, idx_q};

endmodule

// File: doc/uart_pass_ctrl.md
UART_PASS_CTRL -- requirements
Module: uart_pass_ctrl

Interface
REQ-001 SHALL have parameter PASS_LEN, default 4, password length in bytes (legal range 1..4).
REQ-002 SHALL have parameter PASSWORD, default {"B","2","a","1"}, 8*PASS_LEN bits; byte i at [8i+7:8i]; byte 0 is the first byte received.
REQ-003 SHALL have parameter MAX_TRIES, default 3, failed attempts before lockout (legal range 1..3).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rxData  input  8  received byte from the UART receiver.
REQ-007 SHALL have port rxValid  input  1  one-cycle strobe; rxData is valid in that cycle.
REQ-008 SHALL have port txData  output  8  byte offered to the UART transmitter.
REQ-009 SHALL have port txValid  output  1  txData is valid; held until accepted.
REQ-010 SHALL have port txReady  input  1  transmitter accepts the byte when txValid && txReady.
REQ-011 SHALL have port unlocked  output  1  password accepted.
REQ-012 SHALL have port locked  output  1  lockout active.
REQ-013 SHALL have port led  output  6  active-low status: ~{unlocked, locked, tries[1:0], idx[1:0]}.

Function
REQ-014 SHALL implement states COLLECT, CHECK, SEND, DONE and LOCKOUT.
REQ-015 COLLECT: on each rxValid, SHALL compare rxData with PASSWORD byte idx, set a sticky mismatch flag on inequality, and increment idx.
REQ-016 COLLECT: when the byte at idx = PASS_LEN-1 is accepted, SHALL enter CHECK on the next cycle and clear idx to 0.
REQ-017 CHECK: SHALL last exactly 1 cycle and select the response message.
REQ-017a CHECK, no mismatch: message "OK\r\n", tries cleared to 0.
REQ-017b CHECK, mismatch with tries+1 < MAX_TRIES: message "NO\r\n", tries incremented.
REQ-017c CHECK, mismatch with tries+1 = MAX_TRIES: message "LK\r\n", tries incremented.
REQ-018 CHECK: SHALL clear the mismatch flag.
REQ-019 SEND: SHALL drive txValid=1 and txData=msg[ptr] for ptr 0..3, and advance ptr only on txValid && txReady.
REQ-019a SEND: txData SHALL stay stable while txReady=0.
REQ-020 SEND: after the 4th byte is accepted, txValid SHALL be 0 in the next cycle.
REQ-020a SEND exit: "OK" goes to DONE, "NO" goes to COLLECT, "LK" goes to LOCKOUT.
REQ-021 unlocked SHALL rise in the cycle DONE is entered and hold until rst; locked likewise for LOCKOUT.
REQ-022 rxValid outside COLLECT SHALL be ignored: no idx, mismatch or tries change and no buffering.
REQ-023 DONE and LOCKOUT SHALL be terminal; only rst exits them.
REQ-024 Latency: the last password byte's rxValid in cycle N SHALL give txValid=1 in cycle N+2 (CHECK at N+1).

Reset
REQ-025 On rst sampled high, the next state SHALL be COLLECT, with idx=0, ptr=0, tries=0, mismatch=0, txValid=0, txData=8'h00, unlocked=0, locked=0, led=6'b111111.
REQ-026 rst SHALL take priority over rxValid and txReady in the same cycle.
REQ-026a rst asserted mid-SEND SHALL abort the message; no further bytes are offered.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration and the three 4-byte message constants (OK, NO, LK).
REQ-028 The message-byte lookup (message select plus ptr -> byte) SHALL be the single sub-module uart_msg_rom, combinational.
REQ-029 The design SHALL be a single clock domain with no latches; all outputs registered except led, which is a pure inversion of registers.

Verification
REQ-030 Bench SHALL send "1a2B" -> txData sequence 0x4F,0x4B,0x0D,0x0A; unlocked=1; led=6'b011111 (unlocked=1, locked=0, tries=0, idx=0).
REQ-031 Bench SHALL send "1a22" -> "NO\r\n"; tries=1; state returns to COLLECT; a following "1a2B" -> "OK\r\n" and tries=0.
REQ-032 Bench SHALL send three wrong passwords -> "NO\r\n", "NO\r\n", "LK\r\n"; locked=1; a later "1a2B" produces no txValid.
REQ-033 Bench SHALL hold txReady=0 for 5 cycles during SEND -> txValid=1 and txData=0x4F stable throughout; no byte is skipped.
REQ-034 Bench SHALL assert rst after the 2nd response byte is accepted -> txValid=0 next cycle; led=6'b111111; a new "1a2B" is then accepted.
REQ-035 Bench SHALL pulse rxValid with "X" during SEND -> ignored; the next 4 bytes after SEND form a complete attempt.
